// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the data memory LSU (slave).
interface dmem_lsu_if #(
  parameter int ADDR_W = 8
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       dato_i;
  logic              ready_o;
  logic              valid_o;
  logic [31:0]       dato_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, dato_i,
    input  ready_o, valid_o, dato_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, dato_i,
    output ready_o, valid_o, dato_o, err_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data memory with integrated load/store unit: byte-lane stores, sign/zero
// extended loads, one-cycle registered response and misalignment flagging.
// An optional post-reset walk zeroes the whole array before accepting requests.
//
// state    | meaning
// ST_CLEAR | writing zero to word[cnt] each cycle, not ready
// ST_RUN   | accepting one request per cycle
module dmem_lsu #(
  parameter int ADDR_W       = 8,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  dmem_lsu_if.slave bus
);

  localparam int CNT_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  localparam state_e RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [31:0]       dato_q, dato_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  logic              mem_we;
  logic [3:0]        mem_be;
  logic [CNT_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  logic              accept;
  logic              bad;
  logic [1:0]        lane;
  logic [CNT_W-1:0]  widx;
  logic [31:0]       rword;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [3:0]        store_be;

  assign lane = bus.addr_i[1:0];
  assign widx = bus.addr_i[ADDR_W-1:2];

  // Decode the incoming request: alignment check, store lanes and load extraction.
  always_comb begin
    accept     = bus.req_i & ready_q & (state_q == ST_RUN);
    bad        = 1'b0;
    store_data = 32'h0;
    store_be   = 4'h0;
    load_data  = 32'h0;
    rword      = mem_q[widx];
    byte_sel   = rword[{lane, 3'b000} +: 8];
    half_sel   = lane[1] ? rword[31:16] : rword[15:0];
    case (bus.size_i)
      2'b00: begin
        store_data = {4{bus.dato_i[7:0]}};
        store_be   = 4'b0001 << lane;
        load_data  = bus.unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        bad        = lane[0];
        store_data = {2{bus.dato_i[15:0]}};
        store_be   = lane[1] ? 4'b1100 : 4'b0011;
        load_data  = bus.unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      2'b10: begin
        bad        = (lane != 2'b00);
        store_data = bus.dato_i;
        store_be   = 4'b1111;
        load_data  = rword;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  // Next-state, array write port and response generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_idx   = widx;
    mem_wdata = store_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_idx   = cnt_q;
        mem_wdata = 32'h0;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == {CNT_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && !bad && bus.we_i) begin
          mem_we = 1'b1;
          mem_be = store_be;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    ready_d = (state_d == ST_RUN);
    valid_d = accept;
    err_d   = accept & bad;
    dato_d  = (accept && !bad && !bus.we_i) ? load_data : 32'h0;
  end

  // Control and response registers; cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      dato_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      dato_q  <= dato_d;
      err_q   <= err_d;
    end
  end

  // Data array with per-byte write enables; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.dato_o  = dato_q;
  assign bus.err_o   = err_q;

endmodule
